// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM states, default bit
// timing and frame levels. Optional FIFO build: define UART_TX_FIFO_EN.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
  localparam int unsigned DATA_BITS            = 8;
  localparam logic        START_LVL            = 1'b0;
  localparam logic        STOP_LVL             = 1'b1;
  localparam int unsigned FIFO_DEPTH           = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the transmitter FSM. Only instantiated
// when UART_TX_FIFO_EN is defined. Read data is combinational from the head.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned WIDTH = DATA_BITS
) (
  input  logic             clk,
  input  logic             en,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Pointer advance with explicit wrap so non-power-of-two depths also work.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each
// CLKS_PER_BIT clocks. Define UART_TX_FIFO_EN to add a 4-entry request FIFO.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       en,
  input  logic [7:0] data,
  input  logic       start,
  output logic       out,
  output logic       busy,
  output logic       done,
  output logic       full
);

  localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] clk_cnt_n;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          done_n;
  logic          avail;
  logic [7:0]    byte_in;
  logic          last_clk;

`ifdef UART_TX_FIFO_EN
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_data;

  // A push is decided on the current occupancy only, so a same-cycle pop
  // never frees room for a request made while full.
  assign fifo_push = start && !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk      (clk),
    .en       (en),
    .push     (fifo_push),
    .push_data(data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign avail   = fifo_pop;
  assign byte_in = fifo_data;
  assign full    = fifo_full;
`else
  assign avail   = start && (state == IDLE);
  assign byte_in = data;
  assign full    = busy;
`endif

  assign last_clk = (clk_cnt == LAST_CLK);

  // State, counters, shift register and the registered done pulse.
  always_ff @(posedge clk) begin
    if (!en) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      done    <= done_n;
    end
  end

  // Next-state logic and line/busy outputs decoded from the current state.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    done_n    = 1'b0;
    out       = STOP_LVL;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (avail) begin
          shift_n   = byte_in;
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = START;
        end
      end
      START: begin
        out  = START_LVL;
        busy = 1'b1;
        if (last_clk) begin
          clk_cnt_n = '0;
          state_n   = DATA;
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        out  = shift[0];
        busy = 1'b1;
        if (last_clk) begin
          clk_cnt_n = '0;
          shift_n   = {1'b0, shift[7:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_n = '0;
            state_n   = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      STOP: begin
        out  = STOP_LVL;
        busy = 1'b1;
        if (last_clk) begin
          clk_cnt_n = '0;
          state_n   = IDLE;
          done_n    = 1'b1;
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: table of bytes with their
// expected line patterns, a frame scoreboard and a behavioural 16x receiver.
// Extra FIFO sequence compiled when UART_TX_FIFO_EN is defined.
`timescale 1ns/1ps
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = '0;
  logic       out, busy, done, full;

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .en   (en),
    .data (data),
    .start(start),
    .out  (out),
    .busy (busy),
    .done (done),
    .full (full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;  // bit i is the i-th level sent on the line
  } vec_t;

  vec_t       tab [5];
  logic [9:0] exp_q [$];

  // Busy-cycle and done-pulse tallies.
  int busy_cnt = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    busy_cnt <= busy_cnt + ((busy === 1'b1) ? 1 : 0);
    done_cnt <= done_cnt + ((done === 1'b1) ? 1 : 0);
  end

  // Behavioural receiver sampling mid-bit.
  logic [7:0] rx_byte = '0;
  logic [7:0] rx_sh = '0;
  logic       rx_err = 1'b0;
  logic       rx_bad = 1'b0;
  int         rx_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (en === 1'b1 && out === 1'b0) begin
        repeat (CPB / 2 - 1) @(negedge clk);
        rx_bad = (out !== 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_sh[i] = out;
        end
        repeat (CPB) @(negedge clk);
        if (out !== 1'b1) rx_bad = 1'b1;
        rx_byte = rx_sh;
        rx_err  = rx_bad;
        rx_cnt++;
      end
    end
  end

  task automatic drive_start(input logic [7:0] d, input logic [9:0] f, input bit track);
    data  = d;
    start = 1'b1;
    if (track) exp_q.push_back(f);
    @(negedge clk);
    start = 1'b0;
    data  = 8'($urandom);
  endtask

  // Checks one frame cycle by cycle; returns on the cycle after the stop bit.
  task automatic check_frame(input string tag, input int exp_wait, input int inject_at,
                             input int offset);
    logic [9:0] f;
    int w;
    int bad_bit [10];
    int bad_busy, bad_done, bad_full;
    w = 0;
    while (out !== START_LVL && w < 4 * CPB) begin
      @(negedge clk);
      w++;
    end
    checkn({tag, " latency"}, w, exp_wait);
    check1({tag, " scoreboard"}, exp_q.size() > 0, 1'b1);
    if (exp_q.size() == 0) return;
    f = exp_q.pop_front();
    foreach (bad_bit[i]) bad_bit[i] = 0;
    bad_busy = 0;
    bad_done = 0;
    bad_full = 0;
    for (int n = offset; n < FRAME; n++) begin
      if (out !== f[n / CPB]) bad_bit[n / CPB]++;
      if (busy !== 1'b1) bad_busy++;
      if (done !== 1'b0) bad_done++;
`ifndef UART_TX_FIFO_EN
      if (full !== 1'b1) bad_full++;
`endif
      if (n == inject_at) begin
        start = 1'b1;
        data  = 8'hFF;
      end else if (n == inject_at + 1) begin
        start = 1'b0;
        data  = 8'($urandom);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) checkn($sformatf("%s bit%0d bad cycles", tag, i), bad_bit[i], 0);
    checkn({tag, " busy low in frame"}, bad_busy, 0);
    checkn({tag, " done early"}, bad_done, 0);
    checkn({tag, " full low in frame"}, bad_full, 0);
    check1({tag, " done pulse"}, done, 1'b1);
    check1({tag, " busy after"}, busy, 1'b0);
    check1({tag, " out idle after"}, out, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int b0, d0, r0;

  initial begin
    tab[0] = '{8'hA5, 10'b1101001010};
    tab[1] = '{8'h3C, 10'b1001111000};
    tab[2] = '{8'h01, 10'b1000000010};
    tab[3] = '{8'hFF, 10'b1111111110};
    tab[4] = '{8'h00, 10'b1000000000};

    en = 1'b0;
    repeat (3) @(negedge clk);
    check1("reset out", out, 1'b1);
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check1("reset full", full, 1'b0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    check1("idle out", out, 1'b1);

    // Table: single frames with line pattern, busy length, done and loopback.
    for (int i = 0; i < 5; i++) begin
      b0 = busy_cnt;
      d0 = done_cnt;
      r0 = rx_cnt;
      drive_start(tab[i].d, tab[i].frame, 1'b1);
      check_frame($sformatf("vec%0d", i), LAT, -10, 0);
      @(negedge clk);
      check1($sformatf("vec%0d done one cycle", i), done, 1'b0);
      repeat (4) @(negedge clk);
      checkn($sformatf("vec%0d busy cycles", i), busy_cnt - b0, FRAME);
      checkn($sformatf("vec%0d done pulses", i), done_cnt - d0, 1);
      checkn($sformatf("vec%0d rx count", i), rx_cnt - r0, 1);
      checkn($sformatf("vec%0d rx byte", i), int'(rx_byte), int'(tab[i].d));
      check1($sformatf("vec%0d rx err", i), rx_err, 1'b0);
    end

`ifndef UART_TX_FIFO_EN
    // Second request while busy must be ignored.
    r0 = rx_cnt;
    drive_start(tab[0].d, tab[0].frame, 1'b1);
    check_frame("drop", 0, 40, 0);
    repeat (40) @(negedge clk);
    check1("drop no second frame", busy, 1'b0);
    checkn("drop rx count", rx_cnt - r0, 1);
    checkn("drop rx byte", int'(rx_byte), 8'hA5);

    // Reset at cycle 50 of a frame aborts it without a done pulse.
    drive_start(8'h3C, tab[1].frame, 1'b0);
    repeat (50) @(negedge clk);
    check1("abort busy before", busy, 1'b1);
    d0 = done_cnt;
    en = 1'b0;
    @(negedge clk);
    check1("abort out", out, 1'b1);
    check1("abort busy", busy, 1'b0);
    check1("abort done", done, 1'b0);
    check1("abort full", full, 1'b0);
    en = 1'b1;
    repeat (200) @(negedge clk);
    checkn("abort no done", done_cnt - d0, 0);
    r0 = rx_cnt;
    drive_start(tab[2].d, tab[2].frame, 1'b1);
    check_frame("post_reset", 0, -10, 0);
    repeat (5) @(negedge clk);
    checkn("post_reset rx count", rx_cnt - r0, 1);
    checkn("post_reset rx byte", int'(rx_byte), 8'h01);

    // Back-to-back: request in the done cycle.
    b0 = busy_cnt;
    r0 = rx_cnt;
    drive_start(tab[0].d, tab[0].frame, 1'b1);
    check_frame("b2b first", 0, -10, 0);
    drive_start(tab[4].d, tab[4].frame, 1'b1);
    check_frame("b2b second", 0, -10, 0);
    repeat (5) @(negedge clk);
    checkn("b2b busy cycles", busy_cnt - b0, 2 * FRAME);
    checkn("b2b rx count", rx_cnt - r0, 2);
    checkn("b2b rx last", int'(rx_byte), 8'h00);
`else
    // FIFO: leading byte starts the FSM, then 11..55 while busy; 55 dropped.
    d0 = done_cnt;
    drive_start(8'hA5, tab[0].frame, 1'b1);
    check1("fifo latency N+1", out, 1'b1);
    @(negedge clk);
    check1("fifo latency N+2", out, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      logic [7:0] b;
      b = 8'(j * 8'h11);
      drive_start(b, {1'b1, b, 1'b0}, 1'b1);
    end
    check1("fifo full after 4", full, 1'b1);
    drive_start(8'h55, 10'b0, 1'b0);
    check1("fifo full after drop", full, 1'b1);
    check_frame("fifo A5", 0, -10, 5);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check_frame($sformatf("fifo %0d", j), 0, -10, 0);
    end
    repeat (40) @(negedge clk);
    check1("fifo 55 not sent", busy, 1'b0);
    check1("fifo empty full", full, 1'b0);
    checkn("fifo done pulses", done_cnt - d0, 5);
    checkn("fifo rx last", int'(rx_byte), 8'h44);
`endif
    checkn("scoreboard drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
